// File: rtl/qpu_exu_longpwbck_pkg.sv
// Shared QPU widths, measurement FSM encoding and timeout default for the long-pipe writeback.
// QPU_MEAS_TMO_EN (optional macro) enables the measurement timeout in qpu_exu_longpwbck.
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 5
`endif
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif
`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif

package qpu_exu_longpwbck_pkg;

  typedef enum logic [1:0] {
    MS_IDLE    = 2'd0,
    MS_COLLECT = 2'd1,
    MS_WBCK    = 2'd2
  } meas_state_e;

  localparam int QPU_TMO_CYC_DEF = 1024;

endpackage

// File: rtl/qpu_exu_longpwbck_buf.sv
// Single-entry classical result buffer; one cycle from accept to writeback request.
// Refuses new results while occupied or while the OITF is empty.
module qpu_exu_longpwbck_buf #(
  parameter int XLEN = 32,
  parameter int RFW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [XLEN-1:0] in_wdat,
  input  logic [RFW-1:0]  in_rdidx,
  input  logic            in_rdwen,
  input  logic            oitf_empty,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] out_wdat,
  output logic [RFW-1:0]  out_rdidx,
  output logic            ret_ena
);

  logic            buf_vld_q, buf_vld_d;
  logic            buf_rdwen_q, buf_rdwen_d;
  logic [XLEN-1:0] buf_wdat_q, buf_wdat_d;
  logic [RFW-1:0]  buf_rdidx_q, buf_rdidx_d;

  always_comb begin
    buf_vld_d   = buf_vld_q;
    buf_rdwen_d = buf_rdwen_q;
    buf_wdat_d  = buf_wdat_q;
    buf_rdidx_d = buf_rdidx_q;
    in_rdy      = ~rst & ~buf_vld_q & ~oitf_empty;
    // Entries that do not write the register file retire on their first buffered cycle.
    ret_ena     = ~rst & buf_vld_q & (~buf_rdwen_q | out_rdy);
    out_vld     = ~rst & buf_vld_q & buf_rdwen_q;
    if (ret_ena) begin
      buf_vld_d = 1'b0;
    end
    if (in_vld & in_rdy) begin
      buf_vld_d   = 1'b1;
      buf_rdwen_d = in_rdwen;
      buf_wdat_d  = in_wdat;
      buf_rdidx_d = in_rdidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q   <= 1'b0;
      buf_rdwen_q <= 1'b0;
    end else begin
      buf_vld_q   <= buf_vld_d;
      buf_rdwen_q <= buf_rdwen_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_wdat_q  <= buf_wdat_d;
    buf_rdidx_q <= buf_rdidx_d;
  end

  assign out_wdat  = buf_wdat_q;
  assign out_rdidx = buf_rdidx_q;

endmodule

// File: rtl/qpu_exu_longpwbck.sv
// Long-pipe writeback: classical result buffer plus measurement-vector collection FSM.
// Optional macro QPU_MEAS_TMO_EN adds a TMO_CYC-cycle collection timeout reported on mwbck_o_err.
module qpu_exu_longpwbck
  import qpu_exu_longpwbck_pkg::*;
#(
  parameter int QUBIT_NUM = `QPU_QUBIT_NUM,
  parameter int XLEN      = `QPU_XLEN,
  parameter int TMO_CYC   = QPU_TMO_CYC_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             lp_i_valid,
  output logic                             lp_i_ready,
  input  logic [XLEN-1:0]                  lp_i_wdat,
  input  logic                             oitf_empty,
  input  logic [`QPU_RFIDX_REAL_WIDTH-1:0] oitf_ret_rdidx,
  input  logic                             oitf_ret_rdwen,
  output logic                             oitf_ret_cl_ena,
  input  logic                             mf_vld,
  input  logic [QUBIT_NUM-1:0]             oitf_ret_mf,
  output logic                             oitf_ret_qf_ena,
  input  logic                             meas_i_valid,
  output logic                             meas_i_ready,
  input  logic [$clog2(QUBIT_NUM)-1:0]     meas_i_qidx,
  input  logic                             meas_i_res,
  output logic                             wbck_o_valid,
  input  logic                             wbck_o_ready,
  output logic [XLEN-1:0]                  wbck_o_wdat,
  output logic [`QPU_RFIDX_REAL_WIDTH-1:0] wbck_o_rdidx,
  output logic                             mwbck_o_valid,
  input  logic                             mwbck_o_ready,
  output logic [QUBIT_NUM-1:0]             mwbck_o_mask,
  output logic [QUBIT_NUM-1:0]             mwbck_o_res,
  output logic                             mwbck_o_err,
  output logic                             meas_stray
);

  localparam int QW = $clog2(QUBIT_NUM);

  if (TMO_CYC < 2) begin : g_tmo_cyc_invalid
    $error("TMO_CYC must be at least 2");
  end

  qpu_exu_longpwbck_buf #(
    .XLEN (XLEN),
    .RFW  (`QPU_RFIDX_REAL_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (lp_i_valid),
    .in_rdy     (lp_i_ready),
    .in_wdat    (lp_i_wdat),
    .in_rdidx   (oitf_ret_rdidx),
    .in_rdwen   (oitf_ret_rdwen),
    .oitf_empty (oitf_empty),
    .out_vld    (wbck_o_valid),
    .out_rdy    (wbck_o_ready),
    .out_wdat   (wbck_o_wdat),
    .out_rdidx  (wbck_o_rdidx),
    .ret_ena    (oitf_ret_cl_ena)
  );

  meas_state_e          state_q, state_d;
  logic [QUBIT_NUM-1:0] pend_q, pend_d;
  logic [QUBIT_NUM-1:0] mask_q, mask_d;
  logic [QUBIT_NUM-1:0] res_q, res_d;
  logic [QUBIT_NUM-1:0] hit;

`ifdef QPU_MEAS_TMO_EN
  localparam int CW = $clog2(TMO_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    mask_d          = mask_q;
    res_d           = res_q;
    meas_i_ready    = 1'b0;
    mwbck_o_valid   = 1'b0;
    oitf_ret_qf_ena = 1'b0;
    meas_stray      = 1'b0;
`ifdef QPU_MEAS_TMO_EN
    cnt_d           = cnt_q;
    err_d           = err_q;
`endif
    // Out-of-range indices match no bit, so they fall through to the stray path.
    hit = '0;
    for (int i = 0; i < QUBIT_NUM; i++) begin
      hit[i] = (meas_i_qidx == QW'(i));
    end
    unique case (state_q)
      MS_IDLE: begin
        if (mf_vld) begin
          pend_d  = oitf_ret_mf;
          mask_d  = oitf_ret_mf;
          res_d   = '0;
          state_d = (oitf_ret_mf == '0) ? MS_WBCK : MS_COLLECT;
`ifdef QPU_MEAS_TMO_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      MS_COLLECT: begin
        meas_i_ready = 1'b1;
`ifdef QPU_MEAS_TMO_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (meas_i_valid) begin
          if (|(hit & pend_q)) begin
            pend_d = pend_q & ~hit;
            res_d  = (res_q & ~hit) | (hit & {QUBIT_NUM{meas_i_res}});
          end else begin
            meas_stray = 1'b1;
          end
        end
        if (pend_d == '0) begin
          state_d = MS_WBCK;
        end
`ifdef QPU_MEAS_TMO_EN
        else if (cnt_q == TMO_LAST) begin
          state_d = MS_WBCK;
          err_d   = 1'b1;
        end
`endif
      end
      MS_WBCK: begin
        mwbck_o_valid = 1'b1;
        if (mwbck_o_ready) begin
          oitf_ret_qf_ena = 1'b1;
          state_d         = MS_IDLE;
        end
      end
      default: state_d = MS_IDLE;
    endcase
    if (rst) begin
      meas_i_ready    = 1'b0;
      mwbck_o_valid   = 1'b0;
      oitf_ret_qf_ena = 1'b0;
      meas_stray      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      pend_q  <= '0;
      mask_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
    end
  end

`ifdef QPU_MEAS_TMO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mwbck_o_err = err_q;
`else
  assign mwbck_o_err = 1'b0;
`endif

  assign mwbck_o_mask = mask_q;
  assign mwbck_o_res  = res_q;

endmodule
